// File: rtl/pc_seq_pkg.sv
// Shared types for the A09 instruction sequencer. The IRQ state exists only
// when PC_SEQ_IRQ_EN is defined.
package pc_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    VECTOR = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    LOAD   = 3'd3,
    HALT   = 3'd4
`ifdef PC_SEQ_IRQ_EN
    , IRQ  = 3'd5
`endif
  } state_t;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer driving the program counter's active-low load and increment strobes.
// Optional interrupt vectoring with one saved return address is built when PC_SEQ_IRQ_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter logic [DataWidth-1:0] ResetVector = '0
`ifdef PC_SEQ_IRQ_EN
  , parameter logic [DataWidth-1:0] IrqVector = DataWidth'(8'hF0)
`endif
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [DataWidth-1:0] PcIn,
  output logic                 PC_LD,
  output logic                 PC_Inc,
  output logic [DataWidth-1:0] PC_DIn,
  output logic                 MemReq,
  input  logic                 MemAck,
  output logic                 IR_LD,
  input  logic                 ExecDone,
  input  logic                 BranchTaken,
  input  logic [DataWidth-1:0] BranchTarget,
  input  logic                 Halt,
  output logic                 Halted,
  output logic [STATE_W-1:0]   dbg_state
`ifdef PC_SEQ_IRQ_EN
  , input  logic               IrqReq,
  input  logic                 Reti,
  output logic                 IrqAck
`endif
);

  // Handshake: MemReq stays high until a one-cycle MemAck is sampled in FETCH;
  // ExecDone is a one-cycle pulse that qualifies BranchTaken/BranchTarget/Halt/Reti.

  state_t               state;
  state_t               next_state;
  logic                 armed;
  logic                 acked;
  logic [DataWidth-1:0] target;

`ifdef PC_SEQ_IRQ_EN
  logic                 int_en;
  logic [DataWidth-1:0] saved_pc;
  logic                 irq_take;

  assign irq_take = IrqReq && int_en;
`else
  logic unused_pc_in;

  // PcIn only feeds the return address, which this build does not keep.
  assign unused_pc_in = ^PcIn;
`endif

  assign dbg_state = state;

  // armed keeps the reset-vector load off the pins until the first clock after release.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= VECTOR;
      armed <= 1'b0;
      acked <= 1'b0;
    end else begin
      state <= next_state;
      armed <= 1'b1;
      acked <= (state == FETCH) && !acked && MemAck;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      VECTOR: if (armed) next_state = FETCH;
      FETCH:  if (acked) next_state = EXEC;
      EXEC: begin
        if (ExecDone) begin
          if (Halt)              next_state = HALT;
`ifdef PC_SEQ_IRQ_EN
          else if (irq_take)     next_state = IRQ;
          else if (Reti)         next_state = LOAD;
`endif
          else if (BranchTaken)  next_state = LOAD;
          else                   next_state = FETCH;
        end
      end
      LOAD:   next_state = FETCH;
      HALT: begin
`ifdef PC_SEQ_IRQ_EN
        if (irq_take) next_state = IRQ;
`endif
      end
`ifdef PC_SEQ_IRQ_EN
      IRQ:    next_state = FETCH;
`endif
      default: next_state = VECTOR;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      target <= '0;
`ifdef PC_SEQ_IRQ_EN
      int_en   <= 1'b1;
      saved_pc <= '0;
`endif
    end else begin
      if (state == EXEC && ExecDone && !Halt) begin
`ifdef PC_SEQ_IRQ_EN
        if (Reti) begin
          target <= saved_pc;
          int_en <= 1'b1;
        end else if (BranchTaken) begin
          target <= BranchTarget;
        end
        // A taken branch is where the interrupted program resumes.
        if (irq_take) saved_pc <= BranchTaken ? BranchTarget : PcIn;
`else
        if (BranchTaken) target <= BranchTarget;
`endif
      end
`ifdef PC_SEQ_IRQ_EN
      if (state == HALT && irq_take) saved_pc <= PcIn;
      if (next_state == IRQ) int_en <= 1'b0;
`endif
    end
  end

  always_comb begin
    PC_LD  = STROBE_OFF;
    PC_Inc = STROBE_OFF;
    IR_LD  = STROBE_OFF;
    PC_DIn = '0;
    MemReq = 1'b0;
    Halted = 1'b0;
`ifdef PC_SEQ_IRQ_EN
    IrqAck = 1'b0;
`endif
    case (state)
      VECTOR: begin
        if (armed) begin
          PC_LD  = STROBE_ON;
          PC_DIn = ResetVector;
        end
      end
      FETCH: begin
        if (acked) begin
          IR_LD  = STROBE_ON;
          PC_Inc = STROBE_ON;
        end else begin
          MemReq = 1'b1;
        end
      end
      LOAD: begin
        PC_LD  = STROBE_ON;
        PC_DIn = target;
      end
      HALT: Halted = 1'b1;
`ifdef PC_SEQ_IRQ_EN
      IRQ: begin
        PC_LD  = STROBE_ON;
        PC_DIn = IrqVector;
        IrqAck = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer with a behavioural program counter attached; the IRQ
// round trip is exercised only when PC_SEQ_IRQ_EN is defined.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int W = 8;

  logic           Clk = 1'b0;
  logic           Reset = 1'b1;
  logic [W-1:0]   PcIn;
  logic           PC_LD, PC_Inc, IR_LD, MemReq, Halted;
  logic [W-1:0]   PC_DIn;
  logic           MemAck = 1'b0;
  logic           ExecDone = 1'b0;
  logic           BranchTaken = 1'b0;
  logic [W-1:0]   BranchTarget = '0;
  logic           Halt = 1'b0;
  logic [STATE_W-1:0] dbg_state;
`ifdef PC_SEQ_IRQ_EN
  logic           IrqReq = 1'b0;
  logic           Reti = 1'b0;
  logic           IrqAck;
`endif

  int           checks = 0;
  int           errors = 0;
  int           inc_cnt = 0;
  logic [W-1:0] pc_model = '0;
  logic [W-1:0] exp_q[$];

  pc_sequencer #(.DataWidth(W), .ResetVector(8'h10)) dut (
    .Clk(Clk), .Reset(Reset), .PcIn(PcIn),
    .PC_LD(PC_LD), .PC_Inc(PC_Inc), .PC_DIn(PC_DIn),
    .MemReq(MemReq), .MemAck(MemAck), .IR_LD(IR_LD),
    .ExecDone(ExecDone), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Halt(Halt), .Halted(Halted), .dbg_state(dbg_state)
`ifdef PC_SEQ_IRQ_EN
    , .IrqReq(IrqReq), .Reti(Reti), .IrqAck(IrqAck)
`endif
  );

  // clock / reset
  always #5 Clk = ~Clk;

  // program counter as the integrator places it next to the sequencer
  assign PcIn = pc_model;
  always @(posedge Clk) begin
    if (PC_LD == 1'b0)       pc_model <= PC_DIn;
    else if (PC_Inc == 1'b0) pc_model <= pc_model + 8'd1;
  end

  // scoreboard: every PC load strobe must match the next queued target
  always @(negedge Clk) begin
    if (!Reset) begin
      if (PC_Inc == 1'b0) inc_cnt++;
      checks++;
      if (PC_LD == 1'b0 && PC_Inc == 1'b0) begin
        errors++;
        $display("FAIL strobe_excl: PC_LD=%b PC_Inc=%b, required never both 0", PC_LD, PC_Inc);
      end
      if (PC_LD == 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL load_sb: unexpected load PC_DIn=%h, required no load", PC_DIn);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (PC_DIn !== e) begin
            errors++;
            $display("FAIL load_sb: PC_DIn=%h required %h", PC_DIn, e);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  task automatic do_fetch(input int dly, output int inc_seen, output bit ok);
    int start;
    ok = 1'b0;
    inc_seen = 0;
    for (int i = 0; i < 50 && MemReq !== 1'b1; i++) step();
    if (MemReq !== 1'b1) return;
    repeat (dly) step();
    start = inc_cnt;
    MemAck = 1'b1;
    step();
    MemAck = 1'b0;
    step();
    inc_seen = inc_cnt - start;
    ok = 1'b1;
  endtask

  task automatic exec_done(input logic br, input logic [W-1:0] tgt, input logic hlt);
    ExecDone = 1'b1;
    BranchTaken = br;
    BranchTarget = tgt;
    Halt = hlt;
    step();
    ExecDone = 1'b0;
    BranchTaken = 1'b0;
    BranchTarget = '0;
    Halt = 1'b0;
  endtask

  // test tasks
  task automatic test_reset();
    Reset = 1'b1;
    step();
    checks++;
    if ({PC_LD, PC_Inc, IR_LD} !== 3'b111) begin
      errors++; $display("FAIL reset_strobes: got %b required 111", {PC_LD, PC_Inc, IR_LD});
    end
    checks++;
    if ({MemReq, Halted} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got %b required 00", {MemReq, Halted});
    end
    checks++;
    if (PC_DIn !== 8'h00) begin
      errors++; $display("FAIL reset_din: got %h required 00", PC_DIn);
    end
    checks++;
    if (dbg_state !== VECTOR) begin
      errors++; $display("FAIL reset_state: got %0d required %0d", dbg_state, VECTOR);
    end
    exp_q.push_back(8'h10);
    Reset = 1'b0;
    step();
    checks++;
    if (PC_LD !== 1'b0 || PC_DIn !== 8'h10 || MemReq !== 1'b0) begin
      errors++; $display("FAIL vector_load: PC_LD=%b PC_DIn=%h MemReq=%b required 0 10 0", PC_LD, PC_DIn, MemReq);
    end
    step();
    checks++;
    if (MemReq !== 1'b1 || PC_LD !== 1'b1 || dbg_state !== FETCH) begin
      errors++; $display("FAIL first_fetch: MemReq=%b PC_LD=%b state=%0d required 1 1 %0d", MemReq, PC_LD, dbg_state, FETCH);
    end
    checks++;
    if (pc_model !== 8'h10) begin
      errors++; $display("FAIL vector_pc: got %h required 10", pc_model);
    end
  endtask

  task automatic test_fetch();
    int dly[3] = '{0, 2, 5};
    int seen, start;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      do_fetch(dly[i], seen, ok);
      checks++;
      if (!ok || seen != 1) begin
        errors++; $display("FAIL fetch_inc[%0d]: ok=%0d inc pulses=%0d required 1 1", i, ok, seen);
      end
      checks++;
      if (pc_model !== 8'(8'h11 + i) || dbg_state !== EXEC) begin
        errors++; $display("FAIL fetch_pc[%0d]: pc=%h state=%0d required %h %0d", i, pc_model, dbg_state, 8'(8'h11 + i), EXEC);
      end
      if (i == 2) begin
        start = inc_cnt;
        MemAck = 1'b1;
        step();
        MemAck = 1'b0;
        step();
        checks++;
        if (inc_cnt != start || dbg_state !== EXEC) begin
          errors++; $display("FAIL stray_ack: inc pulses=%0d state=%0d required 0 %0d", inc_cnt - start, dbg_state, EXEC);
        end
      end
      exec_done(1'b0, 8'h00, 1'b0);
      checks++;
      if (MemReq !== 1'b1 || dbg_state !== FETCH) begin
        errors++; $display("FAIL refetch[%0d]: MemReq=%b state=%0d required 1 %0d", i, MemReq, dbg_state, FETCH);
      end
    end
  endtask

  task automatic test_branch();
    int seen, start;
    bit ok;
    do_fetch(0, seen, ok);
    checks++;
    if (!ok || pc_model !== 8'h14) begin
      errors++; $display("FAIL branch_pre: ok=%0d pc=%h required 1 14", ok, pc_model);
    end
    start = inc_cnt;
    exp_q.push_back(8'h40);
    exec_done(1'b1, 8'h40, 1'b0);
    checks++;
    if (PC_LD !== 1'b0 || PC_DIn !== 8'h40 || dbg_state !== LOAD) begin
      errors++; $display("FAIL branch_load: PC_LD=%b PC_DIn=%h state=%0d required 0 40 %0d", PC_LD, PC_DIn, dbg_state, LOAD);
    end
    step();
    checks++;
    if (MemReq !== 1'b1 || pc_model !== 8'h40 || inc_cnt != start) begin
      errors++; $display("FAIL branch_post: MemReq=%b pc=%h incs=%0d required 1 40 0", MemReq, pc_model, inc_cnt - start);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_pc = 8'h40;
    logic [W-1:0] tgt;
    logic         br;
    int seen;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      do_fetch($urandom_range(0, 3), seen, ok);
      exp_pc = exp_pc + 8'd1;
      checks++;
      if (!ok || seen != 1 || pc_model !== exp_pc) begin
        errors++; $display("FAIL b2b_fetch[%0d]: ok=%0d incs=%0d pc=%h required 1 1 %h", i, ok, seen, pc_model, exp_pc);
      end
      br = 1'($urandom_range(0, 1));
      tgt = 8'($urandom_range(0, 255));
      if (br) begin
        exp_q.push_back(tgt);
        exp_pc = tgt;
      end
      exec_done(br, tgt, 1'b0);
      if (br) step();
      checks++;
      if (MemReq !== 1'b1 || pc_model !== exp_pc) begin
        errors++; $display("FAIL b2b_exec[%0d]: MemReq=%b pc=%h required 1 %h", i, MemReq, pc_model, exp_pc);
      end
    end
  endtask

  task automatic test_halt();
    logic [W-1:0] pc_hold;
    int bad = 0;
    int seen;
    bit ok;
    do_fetch(1, seen, ok);
    pc_hold = pc_model;
    exec_done(1'b1, 8'h77, 1'b1);
    checks++;
    if (Halted !== 1'b1 || dbg_state !== HALT) begin
      errors++; $display("FAIL halt_enter: Halted=%b state=%0d required 1 %0d", Halted, dbg_state, HALT);
    end
    for (int i = 0; i < 20; i++) begin
      MemAck = 1'($urandom_range(0, 1));
      step();
      if ({PC_LD, PC_Inc, IR_LD, MemReq, Halted} !== 5'b11101) bad++;
    end
    MemAck = 1'b0;
    checks++;
    if (bad != 0 || pc_model !== pc_hold) begin
      errors++; $display("FAIL halt_hold: bad cycles=%0d pc=%h required 0 %h", bad, pc_model, pc_hold);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (Halted !== 1'b0 || dbg_state !== VECTOR) begin
      errors++; $display("FAIL halt_reset: Halted=%b state=%0d required 0 %0d", Halted, dbg_state, VECTOR);
    end
    step();
    exp_q.push_back(8'h10);
    Reset = 1'b0;
    step();
    checks++;
    if (PC_LD !== 1'b0 || PC_DIn !== 8'h10) begin
      errors++; $display("FAIL halt_revector: PC_LD=%b PC_DIn=%h required 0 10", PC_LD, PC_DIn);
    end
    step();
  endtask

  task automatic test_reset_mid_fetch();
    checks++;
    if (MemReq !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: MemReq=%b required 1", MemReq);
    end
    @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if ({MemReq, PC_LD, PC_Inc, IR_LD} !== 4'b0111 || dbg_state !== VECTOR) begin
      errors++; $display("FAIL midrst_drop: MemReq/LD/Inc/IR=%b state=%0d required 0111 %0d", {MemReq, PC_LD, PC_Inc, IR_LD}, dbg_state, VECTOR);
    end
    step();
    exp_q.push_back(8'h10);
    Reset = 1'b0;
    step();
    checks++;
    if (PC_LD !== 1'b0 || PC_DIn !== 8'h10 || dbg_state !== VECTOR) begin
      errors++; $display("FAIL midrst_vector: PC_LD=%b PC_DIn=%h state=%0d required 0 10 %0d", PC_LD, PC_DIn, dbg_state, VECTOR);
    end
    step();
  endtask

`ifdef PC_SEQ_IRQ_EN
  task automatic test_irq();
    int seen;
    bit ok;
    do_fetch(0, seen, ok);
    exp_q.push_back(8'h21);
    exec_done(1'b1, 8'h21, 1'b0);
    step();
    do_fetch(0, seen, ok);
    checks++;
    if (!ok || pc_model !== 8'h22) begin
      errors++; $display("FAIL irq_pre: ok=%0d pc=%h required 1 22", ok, pc_model);
    end
    IrqReq = 1'b1;
    exp_q.push_back(8'hF0);
    exec_done(1'b0, 8'h00, 1'b0);
    checks++;
    if (IrqAck !== 1'b1 || PC_LD !== 1'b0 || PC_DIn !== 8'hF0 || dbg_state !== IRQ) begin
      errors++; $display("FAIL irq_entry: ack=%b ld=%b din=%h state=%0d required 1 0 f0 %0d", IrqAck, PC_LD, PC_DIn, dbg_state, IRQ);
    end
    step();
    checks++;
    if (IrqAck !== 1'b0 || pc_model !== 8'hF0 || MemReq !== 1'b1) begin
      errors++; $display("FAIL irq_vector: ack=%b pc=%h MemReq=%b required 0 f0 1", IrqAck, pc_model, MemReq);
    end
    do_fetch(0, seen, ok);
    exec_done(1'b0, 8'h00, 1'b0);
    checks++;
    if (IrqAck !== 1'b0 || dbg_state !== FETCH) begin
      errors++; $display("FAIL irq_masked: ack=%b state=%0d required 0 %0d", IrqAck, dbg_state, FETCH);
    end
    do_fetch(0, seen, ok);
    Reti = 1'b1;
    exp_q.push_back(8'h22);
    exec_done(1'b0, 8'h00, 1'b0);
    Reti = 1'b0;
    IrqReq = 1'b0;
    checks++;
    if (PC_LD !== 1'b0 || PC_DIn !== 8'h22 || dbg_state !== LOAD) begin
      errors++; $display("FAIL reti_load: ld=%b din=%h state=%0d required 0 22 %0d", PC_LD, PC_DIn, dbg_state, LOAD);
    end
    step();
    checks++;
    if (pc_model !== 8'h22) begin
      errors++; $display("FAIL reti_pc: got %h required 22", pc_model);
    end
  endtask
`endif

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    test_reset();
    test_fetch();
    test_branch();
    test_back_to_back();
    test_halt();
    test_reset_mid_fetch();
`ifdef PC_SEQ_IRQ_EN
    test_irq();
`endif
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d loads outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
